// File: rtl/axi4_lite_read_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi4_lite_read_slave_if                                            |
// | AXI4-Lite read address / read data channel bundle.                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface axi4_lite_read_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport master (
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_read_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi4_lite_read_slave                                               |
// | AXI4-Lite read slave over a 1-cycle-latency synchronous memory.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module axi4_lite_read_slave #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    MEM_DEPTH      = 1024,
  parameter int                    MEM_ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  axi4_lite_read_slave_if.slave     s_axi,
  output logic                      mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data
);

  localparam logic [ADDR_WIDTH-1:0] c_depth   = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [1:0]            c_okay    = 2'b00;
  localparam logic [1:0]            c_slverr  = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_REQ = 2'd1,
    MEM_CAP = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                    r_state;
  logic                      r_addr_pend;
  logic [ADDR_WIDTH-1:0]     r_addr_q;
  logic                      r_arready;
  logic                      r_rvalid;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic [1:0]                r_rresp;
  logic                      r_mem_rd_en;
  logic [MEM_ADDR_WIDTH-1:0] r_mem_rd_addr;

  logic [ADDR_WIDTH-1:0]     w_offset;
  logic [ADDR_WIDTH-1:0]     w_word;
  logic                      w_ok;

  // Subtraction wraps for addresses below the window; the >= test rejects those.
  assign w_offset = r_addr_q - BASE_ADDR;
  assign w_word   = w_offset >> 2;
  assign w_ok     = (r_addr_q[1:0] == 2'b00) && (r_addr_q >= BASE_ADDR) && (w_word < c_depth);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_addr_pend   <= 1'b0;
      r_addr_q      <= '0;
      r_arready     <= 1'b0;
      r_rvalid      <= 1'b0;
      r_rdata       <= '0;
      r_rresp       <= c_okay;
      r_mem_rd_en   <= 1'b0;
      r_mem_rd_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Address captured on the handshake edge is decoded on the following edge.
          if (r_addr_pend) begin
            r_addr_pend <= 1'b0;
            if (w_ok) begin
              r_state       <= MEM_REQ;
              r_mem_rd_en   <= 1'b1;
              r_mem_rd_addr <= w_word[MEM_ADDR_WIDTH-1:0];
            end else begin
              r_state  <= RESP;
              r_rvalid <= 1'b1;
              r_rdata  <= '0;
              r_rresp  <= c_slverr;
            end
          end else if (r_arready && s_axi.S_AXI_ARVALID) begin
            r_addr_q    <= s_axi.S_AXI_ARADDR;
            r_arready   <= 1'b0;
            r_addr_pend <= 1'b1;
          end else begin
            r_arready <= 1'b1;
          end
        end
        MEM_REQ: begin
          r_mem_rd_en <= 1'b0;
          r_state     <= MEM_CAP;
        end
        MEM_CAP: begin
          r_rdata  <= mem_rd_data;
          r_rresp  <= c_okay;
          r_rvalid <= 1'b1;
          r_state  <= RESP;
        end
        RESP: begin
          if (s_axi.S_AXI_RREADY) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_addr_pend <= 1'b0;
          r_arready   <= 1'b0;
          r_rvalid    <= 1'b0;
          r_mem_rd_en <= 1'b0;
        end
      endcase
    end
  end

  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = r_rresp;
  assign mem_rd_en           = r_mem_rd_en;
  assign mem_rd_addr         = r_mem_rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_read_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_axi4_lite_read_slave                                            |
// | Vector table, randomized reads vs reference model, corner cases.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_axi4_lite_read_slave;

  localparam int          MEM_DEPTH = 1024;
  localparam logic [31:0] BASE_ADDR = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [31:0] mem_rd_data = '0;

  axi4_lite_read_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_read_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE_ADDR),
    .MEM_DEPTH(MEM_DEPTH), .MEM_ADDR_WIDTH(10)
  ) dut (
    .clk(clk), .rst(rst), .s_axi(bus),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MEM_DEPTH];
  int          pulse_cnt = 0;
  logic [9:0]  last_rd_addr = '0;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data  <= mem[mem_rd_addr];
      pulse_cnt    <= pulse_cnt + 1;
      last_rd_addr <= mem_rd_addr;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: window arithmetic done in signed 64-bit so underflow is visible.
  function automatic void ref_read(input logic [31:0] a, output logic [1:0] resp,
                                   output logic [31:0] data, output int lat,
                                   output int pulses, output int widx);
    longint off;
    off = longint'(a) - longint'(BASE_ADDR);
    if ((a % 4 == 0) && (off >= 0) && (off / 4 < MEM_DEPTH)) begin
      widx = int'(off / 4); resp = 2'b00; data = mem[widx]; lat = 3; pulses = 1;
    end else begin
      widx = -1; resp = 2'b10; data = '0; lat = 1; pulses = 0;
    end
  endfunction

  // One read; rdelay>0 holds RREADY low and offers a competing address meanwhile.
  task automatic do_read(input logic [31:0] addr, input int rdelay,
                         output logic [31:0] data, output logic [1:0] resp,
                         output int lat, output int pulses, output logic [9:0] raddr,
                         output bit beat_ok);
    int n;
    int p0;
    beat_ok = 1'b1;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b0;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) beat_ok = 1'b0;
    p0 = pulse_cnt;
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = (rdelay == 0);
    lat = 0;
    while (!bus.S_AXI_RVALID && lat < 50) begin @(negedge clk); lat++; end
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    if (rdelay > 0) begin
      bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_ARADDR  = addr + 32'd4;
      repeat (rdelay) begin
        @(negedge clk);
        if (!(bus.S_AXI_RVALID && bus.S_AXI_RDATA === data &&
              bus.S_AXI_RRESP === resp && !bus.S_AXI_ARREADY)) beat_ok = 1'b0;
      end
      bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY  = 1'b1;
    end
    @(negedge clk);
    if (bus.S_AXI_RVALID || !bus.S_AXI_ARREADY || bus.S_AXI_RDATA !== data) beat_ok = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    pulses = pulse_cnt - p0;
    raddr  = last_rd_addr;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          rdelay;
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
    int          pulses;
    logic [9:0]  raddr;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, ed, a;
    logic [1:0]  r, er;
    logic [9:0]  ra;
    int          lt, el, pl, ep, wi, p0, cyc, nhs, nbeat;
    bit          ok, hs;
    int          beat_cyc[3];
    logic [31:0] beat_dat[3];

    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'hA; mem[1] = 32'hB; mem[2] = 32'hC;
    mem[5] = 32'hDEAD_BEEF; mem[1023] = 32'h600D_03FF;

    vecs[0] = '{32'h0000_1014, 0,  2'b00, 32'hDEAD_BEEF, 3, 1, 10'd5};
    vecs[1] = '{32'h0000_1016, 0,  2'b10, 32'h0,         1, 0, 10'd0};
    vecs[2] = '{32'h0000_0FFC, 0,  2'b10, 32'h0,         1, 0, 10'd0};
    vecs[3] = '{32'h0000_2000, 0,  2'b10, 32'h0,         1, 0, 10'd0};
    vecs[4] = '{32'h0000_1FFC, 0,  2'b00, 32'h600D_03FF, 3, 1, 10'd1023};
    vecs[5] = '{32'h0000_2000, 0,  2'b10, 32'h0,         1, 0, 10'd0};
    vecs[6] = '{32'h0000_1014, 10, 2'b00, 32'hDEAD_BEEF, 3, 1, 10'd5};
    vecs[7] = '{32'h0000_0000, 0,  2'b10, 32'h0,         1, 0, 10'd0};
    vecs[8] = '{32'hFFFF_F000, 2,  2'b10, 32'h0,         1, 0, 10'd0};

    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_arready", 32'(bus.S_AXI_ARREADY), 0);
    check("rst_rvalid",  32'(bus.S_AXI_RVALID), 0);
    check("rst_rdata",   bus.S_AXI_RDATA, 0);
    check("rst_rresp",   32'(bus.S_AXI_RRESP), 0);
    check("rst_mem_en",  32'(mem_rd_en), 0);
    check("rst_mem_addr", 32'(mem_rd_addr), 0);
    rst = 1'b0;
    @(negedge clk);
    check("arready_first_edge", 32'(bus.S_AXI_ARREADY), 1);

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      do_read(vecs[i].addr, vecs[i].rdelay, d, r, lt, pl, ra, ok);
      check($sformatf("vec%0d_rdata", i), d, vecs[i].data);
      check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].resp));
      check($sformatf("vec%0d_latency", i), lt, vecs[i].lat);
      check($sformatf("vec%0d_mem_pulses", i), pl, vecs[i].pulses);
      check($sformatf("vec%0d_beat", i), 32'(ok), 1);
      if (vecs[i].pulses == 1) check($sformatf("vec%0d_mem_addr", i), 32'(ra), 32'(vecs[i].raddr));
    end

    // Randomized reads against the reference model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = BASE_ADDR + 4 * $urandom_range(0, MEM_DEPTH - 1);
        1: a = BASE_ADDR + ($urandom_range(0, 4095) & 32'hFFC) + $urandom_range(1, 3);
        2: a = $urandom_range(0, 32'hFFF);
        default: a = $urandom;
      endcase
      ref_read(a, er, ed, el, ep, wi);
      do_read(a, int'($urandom_range(0, 3)), d, r, lt, pl, ra, ok);
      check($sformatf("rnd%0d_rdata@%h", i, a), d, ed);
      check($sformatf("rnd%0d_rresp@%h", i, a), 32'(r), 32'(er));
      check($sformatf("rnd%0d_latency@%h", i, a), lt, el);
      check($sformatf("rnd%0d_pulses@%h", i, a), pl, ep);
      check($sformatf("rnd%0d_beat@%h", i, a), 32'(ok), 1);
      if (ep == 1) check($sformatf("rnd%0d_mem_addr@%h", i, a), 32'(ra), wi);
    end

    // Back-to-back with ARVALID held high
    p0 = pulse_cnt; cyc = 0; nhs = 0; nbeat = 0;
    bus.S_AXI_ARADDR = 32'h1000; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
    while (cyc < 40 && nbeat < 3) begin
      hs = bus.S_AXI_ARREADY && bus.S_AXI_ARVALID;
      @(negedge clk);
      cyc++;
      if (hs) begin
        nhs++;
        if (nhs < 3) bus.S_AXI_ARADDR = 32'h1000 + 32'(4 * nhs);
        else bus.S_AXI_ARVALID = 1'b0;
      end
      if (bus.S_AXI_RVALID) begin
        beat_cyc[nbeat] = cyc; beat_dat[nbeat] = bus.S_AXI_RDATA; nbeat++;
      end
    end
    @(negedge clk);
    bus.S_AXI_RREADY = 1'b0;
    check("b2b_beats", nbeat, 3);
    check("b2b_handshakes", nhs, 3);
    check("b2b_pulses", pulse_cnt - p0, 3);
    check("b2b_data0", beat_dat[0], 32'hA);
    check("b2b_data1", beat_dat[1], 32'hB);
    check("b2b_data2", beat_dat[2], 32'hC);
    check("b2b_gap01", beat_cyc[1] - beat_cyc[0], 5);
    check("b2b_gap12", beat_cyc[2] - beat_cyc[1], 5);

    // Asynchronous reset while a response is stalled
    bus.S_AXI_ARADDR = 32'h1014; bus.S_AXI_ARVALID = 1'b1;
    cyc = 0;
    while (!bus.S_AXI_ARREADY && cyc < 50) begin @(negedge clk); cyc++; end
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    cyc = 0;
    while (!bus.S_AXI_RVALID && cyc < 50) begin @(negedge clk); cyc++; end
    check("pre_reset_rvalid", 32'(bus.S_AXI_RVALID), 1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_rvalid",  32'(bus.S_AXI_RVALID), 0);
    check("async_rst_arready", 32'(bus.S_AXI_ARREADY), 0);
    check("async_rst_rdata",   bus.S_AXI_RDATA, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_arready", 32'(bus.S_AXI_ARREADY), 1);
    check("post_rst_rvalid",  32'(bus.S_AXI_RVALID), 0);
    do_read(32'h1000, 0, d, r, lt, pl, ra, ok);
    check("post_rst_rdata",  d, 32'hA);
    check("post_rst_rresp",  32'(r), 0);
    check("post_rst_latency", lt, 3);
    check("post_rst_pulses", pl, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
